// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, funct3 codes, FSM encoding and packet layouts for mem_stage
package mem_stage_pkg;
  localparam int EX_MEM_BUS = 75;
  localparam int MEM_WB_BUS = 38;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RESP = 2'd2} state_t;
  typedef struct packed {
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
  } ex_mem_t;
  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] wb_data;
  } mem_wb_t;
  function automatic logic access_fault(input ex_mem_t p);
    logic misaligned;
    logic bad_f3;
    misaligned = (p.funct3[1:0] == 2'b01 && p.alu_result[0]) ||
                 (p.funct3[1:0] == 2'b10 && p.alu_result[1:0] != 2'b00);
    bad_f3 = p.mem_ren ? !(p.funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})
                       : !(p.funct3 inside {F3_SB, F3_SH, F3_SW});
    return (p.mem_ren || p.mem_wen) && ((p.mem_ren && p.mem_wen) || bad_f3 || misaligned);
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align: selects and extends the loaded byte/halfword/word for writeback
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] wb_data
);
  logic [31:0] sh;
  always_comb begin
    sh = rdata >> {addr, 3'b000};
    wb_data = funct3 == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
              funct3 == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
              funct3 == F3_LBU ? {24'h0, sh[7:0]} :
              funct3 == F3_LHU ? {16'h0, sh[15:0]} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage driving a req/gnt/rvalid data port and a registered MEM/WB bus
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [EX_MEM_BUS-1:0] ex_mem_bus_in,
  input  logic                  ex_mem_valid,
  output logic                  mem_ready_out,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [31:0]           dmem_addr,
  output logic [3:0]            dmem_wstrb,
  output logic [31:0]           dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [31:0]           dmem_rdata,
  output logic [MEM_WB_BUS-1:0] mem_wb_bus_out,
  output logic                  mem_wb_valid,
  output logic                  mem_fault
);
  state_t      state_q, state_d;
  ex_mem_t     pkt_q, pkt_d, in_pkt;
  mem_wb_t     wb_q, wb_d;
  logic        wb_valid_q, wb_valid_d, fault_q, fault_d;
  logic        accept, in_fault, in_mem;
  logic [1:0]  off;
  logic [31:0] load_data;
  assign in_pkt = ex_mem_t'(ex_mem_bus_in);
  assign off = pkt_q.alu_result[1:0];
  assign accept = ex_mem_valid && state_q == S_IDLE;
  assign in_fault = access_fault(in_pkt);
  assign in_mem = in_pkt.mem_ren || in_pkt.mem_wen;
  assign mem_wb_bus_out = wb_q;
  assign mem_wb_valid = wb_valid_q;
  assign mem_fault = fault_q;
  mem_load_align u_align (
    .rdata   (dmem_rdata),
    .addr    (off),
    .funct3  (pkt_q.funct3),
    .wb_data (load_data)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pkt_q      <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      fault_q    <= fault_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    wb_d       = '0;
    wb_valid_d = 1'b0;
    fault_d    = 1'b0;
    if (accept && (!in_mem || in_fault)) begin
      wb_valid_d = 1'b1;
      fault_d    = in_fault;
      wb_d       = {in_pkt.rd, in_pkt.rd_wen && !in_fault, in_fault ? 32'h0 : in_pkt.alu_result};
    end else if (accept) begin
      pkt_d   = in_pkt;
      state_d = S_REQ;
    end else if (state_q == S_REQ && dmem_gnt) begin
      state_d    = pkt_q.mem_wen ? S_IDLE : S_RESP;
      wb_valid_d = pkt_q.mem_wen;
      wb_d       = pkt_q.mem_wen ? {pkt_q.rd, 1'b0, 32'h0} : '0;
    end else if (state_q == S_RESP && dmem_rvalid) begin
      state_d    = S_IDLE;
      wb_valid_d = 1'b1;
      wb_d       = {pkt_q.rd, pkt_q.rd_wen, load_data};
    end
  end
  always_comb begin
    mem_ready_out = state_q == S_IDLE;
    dmem_req      = state_q == S_REQ;
    dmem_we       = dmem_req && pkt_q.mem_wen;
    dmem_addr     = dmem_req ? {pkt_q.alu_result[31:2], 2'b00} : 32'h0;
    dmem_wstrb    = !dmem_we ? 4'b0000 :
                    pkt_q.funct3[1:0] == 2'b00 ? 4'b0001 << off :
                    pkt_q.funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    dmem_wdata    = !dmem_we ? 32'h0 :
                    pkt_q.funct3[1:0] == 2'b00 ? {4{pkt_q.rs2_data[7:0]}} :
                    pkt_q.funct3[1:0] == 2'b01 ? {2{pkt_q.rs2_data[15:0]}} : pkt_q.rs2_data;
  end
endmodule
